// File: rtl/vector_alu_wb.sv
// Issue controller and writeback buffer for the 8-stage vector ALU.
// Tracks in-flight results alongside the ALU and queues them for register-file writeback.
module vector_alu_wb #(
    parameter int LAT   = 8,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_op,
    input  logic [7:0]       issue_imm,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             issue_is_vec,

    output logic [4:0]       alu_op,
    output logic [7:0]       alu_imm,
    output logic             alu_en,
    input  logic [31:0]      alu_vout [3:0],
    input  logic [31:0]      alu_rout,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_is_vec,
    output logic [31:0]      wb_vdata [3:0],
    output logic [31:0]      wb_rdata,

    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Tracker stage k mirrors what the ALU holds k enabled cycles after issue.
    logic [LAT:1]     trk_valid;
    logic [LAT:1]     trk_vec;
    logic [TAG_W-1:0] trk_tag [1:LAT];

    logic [TAG_W-1:0] fifo_tag   [DEPTH];
    logic             fifo_vec   [DEPTH];
    logic [31:0]      fifo_vdata [DEPTH][4];
    logic [31:0]      fifo_rdata [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic space;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Both handshakes are plain valid/ready: a transfer happens exactly in a
    // cycle where valid and ready are both high, and neither side waits on the
    // other's ready before raising valid.
    assign pop         = wb_valid & wb_ready;
    assign space       = (count < DEPTH_C) | pop;
    assign alu_en      = ~rst & ~flush & (~trk_valid[LAT] | space);
    assign issue_ready = alu_en;
    assign push        = alu_en & trk_valid[LAT];

    assign alu_op  = issue_op;
    assign alu_imm = issue_imm;

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            trk_vec   <= '0;
            for (int k = 1; k <= LAT; k++) begin
                trk_tag[k] <= '0;
            end
        end else if (flush) begin
            trk_valid <= '0;
        end else if (alu_en) begin
            trk_valid[1] <= issue_valid & issue_ready;
            trk_tag[1]   <= issue_tag;
            trk_vec[1]   <= issue_is_vec;
            for (int k = 2; k <= LAT; k++) begin
                trk_valid[k] <= trk_valid[k-1];
                trk_tag[k]   <= trk_tag[k-1];
                trk_vec[k]   <= trk_vec[k-1];
            end
        end
    end

    // The unused result field is zeroed at capture so the head needs no masking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                fifo_tag[e]   <= '0;
                fifo_vec[e]   <= 1'b0;
                fifo_rdata[e] <= '0;
                for (int i = 0; i < 4; i++) begin
                    fifo_vdata[e][i] <= '0;
                end
            end
        end else begin
            if (push) begin
                fifo_tag[wr_ptr]   <= trk_tag[LAT];
                fifo_vec[wr_ptr]   <= trk_vec[LAT];
                fifo_rdata[wr_ptr] <= trk_vec[LAT] ? 32'd0 : alu_rout;
                for (int i = 0; i < 4; i++) begin
                    fifo_vdata[wr_ptr][i] <= trk_vec[LAT] ? alu_vout[i] : 32'd0;
                end
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign wb_valid  = (count != '0);
    assign wb_tag    = fifo_tag[rd_ptr];
    assign wb_is_vec = fifo_vec[rd_ptr];
    assign wb_rdata  = fifo_rdata[rd_ptr];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wb_vdata[i] = fifo_vdata[rd_ptr][i];
        end
    end

    assign busy = ~rst & ((|trk_valid) | wb_valid);

endmodule
